// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: load opcode ranges, access sizes and the split-load state.
package mem_stage_pkg;

   localparam int EXC_W_DEF = 8;

   localparam logic [4:0] MEM_W_LO = 5'd3;
   localparam logic [4:0] MEM_W_HI = 5'd5;
   localparam logic [4:0] MEM_D_LO = 5'd6;
   localparam logic [4:0] MEM_D_HI = 5'd8;
   localparam logic [4:0] MEM_B_LO = 5'd9;
   localparam logic [4:0] MEM_B_HI = 5'd11;

   typedef enum logic {IDLE, HALF} state_e;
   typedef enum logic [1:0] {SZ_NONE, SZ_W, SZ_D, SZ_B} size_e;

   function automatic size_e decode_size(input logic [4:0] op);
      if (op >= MEM_W_LO && op <= MEM_W_HI) return SZ_W;
      if (op >= MEM_D_LO && op <= MEM_D_HI) return SZ_D;
      if (op >= MEM_B_LO && op <= MEM_B_HI) return SZ_B;
      return SZ_NONE;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Formats a RAM read word into zero-extended load data, or merges it with a
// held first half when completing a misaligned load.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  k_i,
   input  size_e       size_i,
   input  logic        second_i,
   input  logic [31:0] part_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;
   logic [5:0]  hi_shamt;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      shifted  = rdata_i >> {k_i, 3'b000};
      hi_shamt = {3'd4 - {1'b0, k_i}, 3'b000};
      data_o   = shifted;
      if (second_i) begin
         // k_i is the offset of the first half; its low bytes of rdata fill the top of the word
         case (size_i)
            SZ_W:    data_o = part_i | (rdata_i << hi_shamt);
            SZ_D:    data_o = {16'h0000, rdata_i[7:0], part_i[7:0]};
            default: data_o = shifted;
         endcase
      end else begin
         case (size_i)
            SZ_D:    data_o = {16'h0000, shifted[15:0]};
            SZ_B:    data_o = {24'h000000, shifted[7:0]};
            default: data_o = shifted;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: formats load data, stitches split loads together and
// registers everything toward writeback.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int EXC_W = EXC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             halt,
   input  logic             bubble_in,
   input  logic [4:0]       opcode_in,
   input  logic [4:0]       tgt_in_1,
   input  logic [4:0]       tgt_in_2,
   input  logic [31:0]      result_in_1,
   input  logic [31:0]      result_in_2,
   input  logic [31:0]      addr_in,
   input  logic             is_load_in,
   input  logic             was_misaligned_in,
   input  logic             tgts_cr_in,
   input  logic [EXC_W-1:0] exc_in,
   input  logic [31:0]      pc_in,
   input  logic [31:0]      mem_rdata,
   input  logic             flush,
   output logic [31:0]      result_out_1,
   output logic [31:0]      result_out_2,
   output logic [4:0]       tgt_out_1,
   output logic [4:0]       tgt_out_2,
   output logic             tgts_cr_out,
   output logic             is_load_out,
   output logic             bubble_out,
   output logic [EXC_W-1:0] exc_out,
   output logic [31:0]      pc_out,
   output logic             split_pending
);

   state_e           state_q, state_d;
   logic [31:0]      part_q, part_d;
   logic [1:0]       part_k_q, part_k_d;
   size_e            part_size_q, part_size_d;
   logic [31:0]      res1_q, res1_d, res2_q, res2_d, pc_q, pc_d;
   logic [4:0]       tgt1_q, tgt1_d, tgt2_q, tgt2_d;
   logic             cr_q, cr_d, isload_q, isload_d, bubble_q, bubble_d;
   logic [EXC_W-1:0] exc_q, exc_d;

   logic [1:0]  k;
   size_e       size;
   logic        crosses, completing, stalled, orphan, kill;
   logic [31:0] aligned;
   logic        unused_addr;

   assign unused_addr = ^addr_in[31:2];
   assign k           = addr_in[1:0];
   assign size        = decode_size(opcode_in);
   assign crosses     = (size == SZ_W && k != 2'd0) || (size == SZ_D && k == 2'd3);
   assign completing  = (state_q == HALF) && was_misaligned_in;
   assign stalled     = (state_q == HALF) && !was_misaligned_in && bubble_in;
   // A second half with no held first half (e.g. after a flush) is dropped
   assign orphan      = (state_q == IDLE) && was_misaligned_in && is_load_in && !bubble_in;

   load_align u_align (
      .rdata_i  (mem_rdata),
      .k_i      (completing ? part_k_q : k),
      .size_i   (completing ? part_size_q : size),
      .second_i (completing),
      .part_i   (part_q),
      .data_o   (aligned)
   );

   always_comb begin
      state_d     = IDLE;
      part_d      = part_q;
      part_k_d    = part_k_q;
      part_size_d = part_size_q;
      pc_d        = pc_in;
      res1_d      = result_in_1;
      res2_d      = result_in_2;
      tgt1_d      = tgt_in_1;
      tgt2_d      = tgt_in_2;
      cr_d        = tgts_cr_in;
      isload_d    = is_load_in;
      bubble_d    = 1'b0;
      exc_d       = exc_in;
      kill        = 1'b0;

      if (flush) begin
         kill   = 1'b1;
         part_d = '0;
      end else if (completing) begin
         res1_d   = aligned;
         isload_d = 1'b1;
      end else if (stalled) begin
         state_d = HALF;
         kill    = 1'b1;
      end else if (bubble_in || orphan) begin
         kill = 1'b1;
      end else if (crosses && !was_misaligned_in) begin
         kill = 1'b1;
         if (is_load_in) begin
            state_d     = HALF;
            part_d      = aligned;
            part_k_d    = k;
            part_size_d = size;
         end
      end else if (is_load_in && size != SZ_NONE) begin
         res1_d = aligned;
      end

      if (kill) begin
         bubble_d = 1'b1;
         tgt1_d   = '0;
         tgt2_d   = '0;
         cr_d     = 1'b0;
         isload_d = 1'b0;
         exc_d    = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         part_q      <= '0;
         part_k_q    <= '0;
         part_size_q <= SZ_NONE;
         res1_q      <= '0;
         res2_q      <= '0;
         pc_q        <= '0;
         tgt1_q      <= '0;
         tgt2_q      <= '0;
         cr_q        <= 1'b0;
         isload_q    <= 1'b0;
         bubble_q    <= 1'b1;
         exc_q       <= '0;
      end else if (clk_en && !halt) begin
         state_q     <= state_d;
         part_q      <= part_d;
         part_k_q    <= part_k_d;
         part_size_q <= part_size_d;
         res1_q      <= res1_d;
         res2_q      <= res2_d;
         pc_q        <= pc_d;
         tgt1_q      <= tgt1_d;
         tgt2_q      <= tgt2_d;
         cr_q        <= cr_d;
         isload_q    <= isload_d;
         bubble_q    <= bubble_d;
         exc_q       <= exc_d;
      end
   end

   assign result_out_1  = res1_q;
   assign result_out_2  = res2_q;
   assign tgt_out_1     = tgt1_q;
   assign tgt_out_2     = tgt2_q;
   assign tgts_cr_out   = cr_q;
   assign is_load_out   = isload_q;
   assign bubble_out    = bubble_q;
   assign exc_out       = exc_q;
   assign pc_out        = pc_q;
   assign split_pending = (state_q == HALF);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a byte-level reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mem_stage;

   logic        clk, rst, clk_en, halt, bubble_in, is_load_in, was_misaligned_in, tgts_cr_in, flush;
   logic [4:0]  opcode_in, tgt_in_1, tgt_in_2;
   logic [31:0] result_in_1, result_in_2, addr_in, pc_in, mem_rdata;
   logic [7:0]  exc_in;
   logic [31:0] result_out_1, result_out_2, pc_out;
   logic [4:0]  tgt_out_1, tgt_out_2;
   logic        tgts_cr_out, is_load_out, bubble_out, split_pending;
   logic [7:0]  exc_out;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage #(.EXC_W(8)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .bubble_in(bubble_in),
      .opcode_in(opcode_in), .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2),
      .result_in_1(result_in_1), .result_in_2(result_in_2), .addr_in(addr_in),
      .is_load_in(is_load_in), .was_misaligned_in(was_misaligned_in), .tgts_cr_in(tgts_cr_in),
      .exc_in(exc_in), .pc_in(pc_in), .mem_rdata(mem_rdata), .flush(flush),
      .result_out_1(result_out_1), .result_out_2(result_out_2),
      .tgt_out_1(tgt_out_1), .tgt_out_2(tgt_out_2), .tgts_cr_out(tgts_cr_out),
      .is_load_out(is_load_out), .bubble_out(bubble_out), .exc_out(exc_out),
      .pc_out(pc_out), .split_pending(split_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: expected outputs and the held bytes of a first half
   logic [31:0] e_res1, e_res2, e_pc;
   logic [4:0]  e_tgt1, e_tgt2;
   logic        e_cr, e_isload, e_bubble, e_split;
   logic [7:0]  e_exc;
   logic [7:0]  held[$];
   int          held_need;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int size_bytes(input logic [4:0] op);
      if (op >= 3 && op <= 5)  return 4;
      if (op >= 6 && op <= 8)  return 2;
      if (op >= 9 && op <= 11) return 1;
      return 0;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
      return 8'((w >> (8 * i)) & 32'hff);
   endfunction

   task automatic model_kill();
      e_bubble = 1'b1; e_tgt1 = '0; e_tgt2 = '0; e_cr = 1'b0; e_isload = 1'b0; e_exc = '0;
   endtask

   task automatic model_pass();
      e_bubble = 1'b0; e_tgt1 = tgt_in_1; e_tgt2 = tgt_in_2; e_cr = tgts_cr_in;
      e_isload = is_load_in; e_exc = exc_in; e_res1 = result_in_1; e_res2 = result_in_2;
   endtask

   task automatic model_step();
      int n, k;
      logic [31:0] v;
      if (rst) begin
         e_res1 = '0; e_res2 = '0; e_pc = '0; e_tgt1 = '0; e_tgt2 = '0;
         e_cr = 1'b0; e_isload = 1'b0; e_bubble = 1'b1; e_exc = '0; e_split = 1'b0;
         held.delete();
         return;
      end
      if (!clk_en || halt) return;
      e_pc = pc_in;
      n = size_bytes(opcode_in);
      k = int'(addr_in[1:0]);
      if (flush) begin
         model_kill(); e_split = 1'b0; held.delete();
      end else if (e_split && was_misaligned_in) begin
         model_pass();
         v = '0;
         foreach (held[i]) v |= 32'(held[i]) << (8 * i);
         for (int i = 0; i < held_need - held.size(); i++)
            v |= 32'(byte_of(mem_rdata, i)) << (8 * (held.size() + i));
         e_res1 = v; e_isload = 1'b1; e_split = 1'b0; held.delete();
      end else if (e_split && bubble_in) begin
         model_kill();
      end else begin
         e_split = 1'b0; held.delete();
         if (bubble_in || (is_load_in && was_misaligned_in)) begin
            model_kill();
         end else if (n != 0 && k + n > 4) begin
            model_kill();
            if (is_load_in) begin
               e_split = 1'b1; held_need = n;
               for (int i = k; i < 4; i++) held.push_back(byte_of(mem_rdata, i));
            end
         end else begin
            model_pass();
            if (is_load_in && n != 0) begin
               v = '0;
               for (int i = 0; i < n; i++) v |= 32'(byte_of(mem_rdata, k + i)) << (8 * i);
               e_res1 = v;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("bubble_out", 32'(bubble_out), 32'(e_bubble));
      check("split_pending", 32'(split_pending), 32'(e_split));
      check("tgt_out_1", 32'(tgt_out_1), 32'(e_tgt1));
      check("tgt_out_2", 32'(tgt_out_2), 32'(e_tgt2));
      check("tgts_cr_out", 32'(tgts_cr_out), 32'(e_cr));
      check("is_load_out", 32'(is_load_out), 32'(e_isload));
      check("exc_out", 32'(exc_out), 32'(e_exc));
      check("pc_out", pc_out, e_pc);
      if (!e_bubble) begin
         check("result_out_1", result_out_1, e_res1);
         check("result_out_2", result_out_2, e_res2);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      rst = 0; clk_en = 1; halt = 0; bubble_in = 0; opcode_in = 0; tgt_in_1 = 0; tgt_in_2 = 0;
      result_in_1 = 0; result_in_2 = 0; addr_in = 0; is_load_in = 0; was_misaligned_in = 0;
      tgts_cr_in = 0; exc_in = 0; pc_in = 0; mem_rdata = 0; flush = 0;
   endtask

   task automatic load(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rd,
                       input logic [4:0] t1, input logic wm);
      idle_inputs();
      opcode_in = op; addr_in = a; mem_rdata = rd; tgt_in_1 = t1; is_load_in = 1;
      was_misaligned_in = wm; pc_in = a + 32'h1000;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      step(); step();
      check("reset bubble", 32'(bubble_out), 32'h1);
      check("reset split", 32'(split_pending), 32'h0);
      check("reset result_1", result_out_1, 32'h0);
      check("reset tgt_1", 32'(tgt_out_1), 32'h0);
      check("reset pc", pc_out, 32'h0);

      // Aligned word with post-increment base
      load(5'd3, 32'h100, 32'hDEADBEEF, 5'd5, 0);
      result_in_2 = 32'h104; tgt_in_2 = 5'd2; exc_in = 8'h00;
      step();
      check("word result", result_out_1, 32'hDEADBEEF);
      check("word tgt", 32'(tgt_out_1), 32'd5);
      check("word bubble", 32'(bubble_out), 32'h0);
      check("word is_load", 32'(is_load_out), 32'h1);
      check("word postinc", result_out_2, 32'h104);

      // Hold: outputs must not move
      load(5'd9, 32'h102, 32'h11223344, 5'd6, 0);
      halt = 1; step();
      check("halt keeps result", result_out_1, 32'hDEADBEEF);
      halt = 0; clk_en = 0; step();
      check("clk_en keeps tgt", 32'(tgt_out_1), 32'd5);

      load(5'd9, 32'h102, 32'h11223344, 5'd6, 0); step();
      check("byte k2", result_out_1, 32'h00000022);
      load(5'd6, 32'h102, 32'h11223344, 5'd6, 0); step();
      check("double k2", result_out_1, 32'h00001122);
      load(5'd11, 32'h103, 32'hF0E1D2C3, 5'd7, 0); step();
      load(5'd4, 32'h102, 32'hCAFEF00D, 5'd8, 0); step();

      // Misaligned word k=1 with an execute stall in between
      load(5'd3, 32'h201, 32'hAABBCCDD, 5'd0, 0); step();
      check("split1 bubble", 32'(bubble_out), 32'h1);
      check("split1 pending", 32'(split_pending), 32'h1);
      idle_inputs(); bubble_in = 1; step();
      load(5'd3, 32'h204, 32'h55667788, 5'd9, 1);
      result_in_2 = 32'h208; tgt_in_2 = 5'd3; step();
      check("split word", result_out_1, 32'h88AABBCC);
      check("split done", 32'(split_pending), 32'h0);

      // Misaligned double k=3
      load(5'd7, 32'h303, 32'h12000000, 5'd0, 0); step();
      load(5'd7, 32'h304, 32'h00000034, 5'd10, 1); step();
      check("split double", result_out_1, 32'h00003412);

      // Misaligned word k=3
      load(5'd3, 32'h403, 32'h99000000, 5'd0, 0); step();
      load(5'd3, 32'h404, 32'hA1B2C3D4, 5'd11, 1); step();

      // ALU pass-through with exception code, then a bubble
      idle_inputs(); opcode_in = 5'd1; result_in_1 = 32'h1234; result_in_2 = 32'h5678;
      tgt_in_1 = 5'd12; tgt_in_2 = 5'd13; tgts_cr_in = 1; exc_in = 8'h05; pc_in = 32'h500;
      step();
      check("alu exc", 32'(exc_out), 32'h05);
      bubble_in = 1; step();
      check("bubble exc", 32'(exc_out), 32'h00);

      // Split store first half is a bubble
      idle_inputs(); opcode_in = 5'd4; addr_in = 32'h602; result_in_1 = 32'h77; step();
      idle_inputs(); opcode_in = 5'd4; addr_in = 32'h604; was_misaligned_in = 1;
      result_in_1 = 32'h88; tgt_in_1 = 5'd14; step();

      // Flush during a split wins over completion; the orphan half is dropped
      load(5'd3, 32'h702, 32'h01020304, 5'd0, 0); step();
      load(5'd3, 32'h704, 32'h05060708, 5'd15, 1); flush = 1; step();
      check("flush bubble", 32'(bubble_out), 32'h1);
      check("flush pending", 32'(split_pending), 32'h0);
      load(5'd3, 32'h704, 32'h05060708, 5'd15, 1); step();
      check("orphan bubble", 32'(bubble_out), 32'h1);

      // Reset while holding a first half with the stage disabled
      load(5'd3, 32'h801, 32'hAABBCCDD, 5'd0, 0); step();
      idle_inputs(); clk_en = 0; rst = 1; step();
      check("rst hold bubble", 32'(bubble_out), 32'h1);
      check("rst hold pending", 32'(split_pending), 32'h0);
      check("rst hold result", result_out_1, 32'h0);
      idle_inputs();
      load(5'd10, 32'h900, 32'h000000AB, 5'd1, 0); step();
      check("after rst byte", result_out_1, 32'h000000AB);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
